// File: rtl/otter_line_mem.sv
// otter_line_mem: line-granular backing memory behind the OTTER cache.
// A request waits a fixed LATENCY. A read then returns a word-serial burst,
// and a write returns a single acknowledge beat.
// Optional build macro: OTTER_LINE_MEM_CWF_EN. When it is defined, a read burst
// starts at the requested word (critical word first) and wraps around the line.
module otter_line_mem #(
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned DEPTH_LINES    = 1024,
  parameter int unsigned LATENCY        = 10
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_we,
  input  logic [31:0]                         req_addr,
  input  logic [32*WORDS_PER_LINE-1:0]        req_wdata,
  output logic                                resp_valid,
  output logic                                resp_last,
  output logic [$clog2(WORDS_PER_LINE)-1:0]   resp_word_idx,
  output logic [31:0]                         resp_rdata
);

  localparam int WIDX = $clog2(WORDS_PER_LINE);
  localparam int LIDX = $clog2(DEPTH_LINES);
  localparam int OB   = WIDX + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WACK} state_t;

  state_t                       state_q, state_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic                         we_q, we_d;
  logic [LIDX-1:0]              line_q, line_d;
  logic [WIDX-1:0]              off_q, off_d;
  logic [32*WORDS_PER_LINE-1:0] wdata_q, wdata_d;
  logic [WIDX-1:0]              beat_q, beat_d;
  logic                         ready_q, ready_d;
  logic                         vld_q, vld_d;
  logic                         last_q, last_d;
  logic [WIDX-1:0]              idx_q, idx_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         mem_we;
  logic [WIDX-1:0]              start;

  // Contents survive RESET and are never cleared.
  logic [31:0] mem_q [DEPTH_LINES][WORDS_PER_LINE];

`ifdef OTTER_LINE_MEM_CWF_EN
  assign start = off_q;
`else
  assign start = '0;
  logic unused_off;
  assign unused_off = ^off_q;
`endif

  logic unused_addr;
  assign unused_addr = ^{req_addr[31:OB+LIDX], req_addr[1:0]};

  assign req_ready     = ready_q;
  assign resp_valid    = vld_q;
  assign resp_last     = last_q;
  assign resp_word_idx = idx_q;
  assign resp_rdata    = rdata_q;

  // Next state and the value of every registered output for the next cycle.
  // Output data fields default to 0, so they stay 0 whenever no beat is shown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    line_d  = line_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    idx_d   = '0;
    rdata_d = '0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_WAIT;
          cnt_d   = 8'(LATENCY - 1);
          we_d    = req_we;
          line_d  = req_addr[OB+LIDX-1:OB];
          off_d   = req_addr[OB-1:2];
          wdata_d = req_wdata;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          vld_d = 1'b1;
          if (we_q) begin
            state_d = S_WACK;
            last_d  = 1'b1;
            mem_we  = 1'b1;
          end else begin
            state_d = S_BURST;
            beat_d  = '0;
            idx_d   = start;
            rdata_d = mem_q[line_q][start];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_BURST: begin
        if (beat_q != '1) begin
          beat_d  = beat_q + WIDX'(1);
          idx_d   = idx_q + WIDX'(1);
          rdata_d = mem_q[line_q][idx_d];
          vld_d   = 1'b1;
          last_d  = (beat_d == '1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Ready is registered, so it first rises one edge after RESET is released.
    ready_d = (state_d == S_IDLE);
  end

  // Control and output registers. Reset abandons any transaction that is in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      line_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      line_q  <= line_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit the whole line on the edge that enters S_WACK.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
        mem_q[line_q][i[WIDX-1:0]] <= wdata_q[32*i +: 32];
      end
    end
  end

endmodule

// File: tb/tb_otter_line_mem.sv
// Directed testbench for otter_line_mem.
// It drives a default-latency instance and a LATENCY=1 instance.
module tb_otter_line_mem;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RESET;
  logic         rv, rr, rwe, vv, vl;
  logic [31:0]  ra, vd;
  logic [255:0] rwd;
  logic [2:0]   vi;
  logic         rv1, rr1, rwe1, vv1, vl1;
  logic [31:0]  ra1, vd1;
  logic [255:0] rwd1;
  logic [2:0]   vi1;

  int checks = 0;
  int errors = 0;

  otter_line_mem #(.WORDS_PER_LINE(8), .DEPTH_LINES(1024), .LATENCY(10)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(rv), .req_ready(rr), .req_we(rwe),
    .req_addr(ra), .req_wdata(rwd), .resp_valid(vv), .resp_last(vl),
    .resp_word_idx(vi), .resp_rdata(vd)
  );

  otter_line_mem #(.WORDS_PER_LINE(8), .DEPTH_LINES(1024), .LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .req_valid(rv1), .req_ready(rr1), .req_we(rwe1),
    .req_addr(ra1), .req_wdata(rwd1), .resp_valid(vv1), .resp_last(vl1),
    .resp_word_idx(vi1), .resp_rdata(vd1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for ready, then present one request for exactly one edge.
  task automatic issue0(input logic we, input logic [31:0] addr, input logic [255:0] wd);
    int n = 0;
    while (rr !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (rr !== 1'b1) begin errors++; $display("FAIL issue_ready got %b want 1", rr); end
    rv = 1'b1; rwe = we; ra = addr; rwd = wd;
    tick();
    rv = 1'b0; rwe = 1'b0; ra = '0; rwd = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    rv = 0; rwe = 0; ra = '0; rwd = '0;
    rv1 = 0; rwe1 = 0; ra1 = '0; rwd1 = '0;
    repeat (3) tick();
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rr); end
    checks++; if (vv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vv); end
    checks++; if (rr1 !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b want 0", rr1); end
    RESET = 1'b0;
    #1;
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", rr); end
    tick();
    checks++; if (rr !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", rr); end
    checks++; if (rr1 !== 1'b1) begin errors++; $display("FAIL ready1_after_release got %b want 1", rr1); end
    checks++; if (vv !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", vv); end
  endtask

  task automatic test_write();
    logic [255:0] wd;
    int early = 0;
    for (int i = 0; i < 8; i++) wd[32*i +: 32] = 32'h11111111 * i;
    issue0(1'b1, 32'h0000_0040, wd);
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL wr_ready_drop got %b want 0", rr); end
    for (int j = 1; j < 10; j++) begin tick(); if (vv !== 1'b0) early++; end
    checks++; if (early != 0) begin errors++; $display("FAIL wr_early_beats got %0d want 0", early); end
    tick();
    checks++; if (vv !== 1'b1) begin errors++; $display("FAIL wack_valid got %b want 1", vv); end
    checks++; if (vl !== 1'b1) begin errors++; $display("FAIL wack_last got %b want 1", vl); end
    checks++; if (vd !== 32'h0) begin errors++; $display("FAIL wack_rdata got %h want 0", vd); end
    checks++; if (vi !== 3'd0) begin errors++; $display("FAIL wack_idx got %0d want 0", vi); end
    tick();
    checks++; if (vv !== 1'b0) begin errors++; $display("FAIL wack_single got %b want 0", vv); end
    checks++; if (rr !== 1'b1) begin errors++; $display("FAIL wack_ready got %b want 1", rr); end
  endtask

  task automatic test_read(input logic [31:0] addr, input int start, input logic [31:0] mult);
    int early = 0;
    logic [2:0] ei;
    issue0(1'b0, addr, '0);
    for (int j = 1; j < 10; j++) begin tick(); if (vv !== 1'b0) early++; end
    checks++; if (early != 0) begin errors++; $display("FAIL rd_early_beats got %0d want 0", early); end
    for (int n = 0; n < 8; n++) begin
      tick();
      ei = 3'(start + n);
      checks++; if (vv !== 1'b1) begin errors++; $display("FAIL rd_valid beat %0d got %b want 1", n, vv); end
      checks++; if (vi !== ei) begin errors++; $display("FAIL rd_idx beat %0d got %0d want %0d", n, vi, ei); end
      checks++; if (vd !== mult * 32'(ei)) begin errors++; $display("FAIL rd_data beat %0d got %h want %h", n, vd, mult * 32'(ei)); end
      checks++; if (vl !== (n == 7)) begin errors++; $display("FAIL rd_last beat %0d got %b want %b", n, vl, (n == 7)); end
    end
    tick();
    checks++; if (vv !== 1'b0) begin errors++; $display("FAIL rd_extra_beat got %b want 0", vv); end
    checks++; if (rr !== 1'b1) begin errors++; $display("FAIL rd_ready_after got %b want 1", rr); end
  endtask

  task automatic test_cwf();
`ifdef OTTER_LINE_MEM_CWF_EN
    test_read(32'h0000_0054, 5, 32'h11111111);
`else
    test_read(32'h0000_0054, 0, 32'h11111111);
`endif
  endtask

  task automatic test_reset_mid_write();
    int stray = 0;
    issue0(1'b1, 32'h0000_0080, {8{32'hDEADBEEF}});
    repeat (4) tick();
    RESET = 1'b1;
    #1;
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", rr); end
    tick();
    RESET = 1'b0;
    for (int j = 0; j < 15; j++) begin tick(); if (vv !== 1'b0) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stray_beats got %0d want 0", stray); end
    test_read(32'h0000_0080, 0, 32'h0);
  endtask

  task automatic test_latency1();
    logic [255:0] wd;
    int n = 0;
    for (int i = 0; i < 8; i++) wd[32*i +: 32] = 32'hA5000000 | 32'(i);
    while (rr1 !== 1'b1 && n < 50) begin tick(); n++; end
    rv1 = 1'b1; rwe1 = 1'b1; ra1 = '0; rwd1 = wd;
    tick();
    rv1 = 1'b0; rwe1 = 1'b0; rwd1 = '0;
    checks++; if (vv1 !== 1'b0) begin errors++; $display("FAIL l1_wr_early got %b want 0", vv1); end
    tick();
    checks++; if (vv1 !== 1'b1 || vl1 !== 1'b1) begin errors++; $display("FAIL l1_wack got %b%b want 11", vv1, vl1); end
    tick();
    checks++; if (rr1 !== 1'b1) begin errors++; $display("FAIL l1_ready got %b want 1", rr1); end
    // Hold req_valid through the whole burst.
    rv1 = 1'b1; rwe1 = 1'b0; ra1 = '0;
    tick();
    checks++; if (rr1 !== 1'b0 || vv1 !== 1'b0) begin errors++; $display("FAIL l1_accept got rdy %b vld %b want 0 0", rr1, vv1); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (vv1 !== 1'b1 || vi1 !== 3'(k) || vd1 !== (32'hA5000000 | 32'(k)) || vl1 !== (k == 7) || rr1 !== 1'b0) begin
        errors++;
        $display("FAIL l1_beat %0d got v%b i%0d d%h l%b r%b want v1 i%0d d%h l%b r0",
                 k, vv1, vi1, vd1, vl1, rr1, k, 32'hA5000000 | 32'(k), (k == 7));
      end
    end
    tick();
    checks++; if (vv1 !== 1'b0 || rr1 !== 1'b1) begin errors++; $display("FAIL l1_idle got v%b r%b want v0 r1", vv1, rr1); end
    tick();
    checks++; if (vv1 !== 1'b0 || rr1 !== 1'b0) begin errors++; $display("FAIL l1_held_accept got v%b r%b want v0 r0", vv1, rr1); end
    rv1 = 1'b0;
    tick();
    checks++; if (vv1 !== 1'b1 || vi1 !== 3'd0) begin errors++; $display("FAIL l1_second_burst got v%b i%0d want v1 i0", vv1, vi1); end
    repeat (8) tick();
    checks++; if (rr1 !== 1'b1 || vv1 !== 1'b0) begin errors++; $display("FAIL l1_drain got r%b v%b want r1 v0", rr1, vv1); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read(32'h0000_0040, 0, 32'h11111111);
    test_cwf();
    test_reset_mid_write();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
